// File: rtl/lbdr_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lbdr_output_arbiter
// Description : Per-output round-robin switch allocator that holds a grant for a
//               whole packet and pops the granted FIFO under credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module lbdr_output_arbiter #(
    parameter int         CREDITS   = 4,
    parameter int         CW        = 3,
    parameter logic [2:0] FLIT_TAIL = 3'b100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    req_i,
    input  logic [4:0]    empty_i,
    input  logic [14:0]   flit_id_i,
    input  logic          credit_in,
    output logic [4:0]    grant_o,
    output logic [2:0]    sel_o,
    output logic [4:0]    read_en_o,
    output logic          valid_o,
    output logic [CW-1:0] credit_cnt_o
);

    localparam logic [0:0]    c_ST_IDLE  = 1'b0;
    localparam logic [0:0]    c_ST_BUSY  = 1'b1;
    localparam logic [2:0]    c_PTR_RST  = 3'd4;
    localparam logic [CW-1:0] c_CRED_MAX = CW'(CREDITS);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [2:0]    r_ptr;
    logic [2:0]    w_ptr_nxt;
    logic [4:0]    r_grant;
    logic [4:0]    w_grant_nxt;
    logic [2:0]    r_sel;
    logic [2:0]    w_sel_nxt;
    logic [CW-1:0] r_credit_cnt;
    logic [CW-1:0] w_credit_nxt;

    logic          w_req_found;
    logic [2:0]    w_winner;
    logic [2:0]    w_scan;
    logic [2:0]    w_head_flit;
    logic          w_cred_ok;
    logic [4:0]    w_pop;
    logic          w_tail_pop;

    // Successor of a port index in N,E,W,S,L order with wrap back to N.
    function automatic logic [2:0] f_next(input logic [2:0] i_idx);
        return (i_idx >= 3'd4) ? 3'd0 : i_idx + 3'd1;
    endfunction

    // Round-robin scan: lowest-priority port is the last one served (r_ptr).
    always_comb begin
        w_req_found = 1'b0;
        w_winner    = 3'd0;
        w_scan      = f_next(r_ptr);
        for (int k = 0; k < 5; k++) begin
            if (!w_req_found && req_i[w_scan]) begin
                w_req_found = 1'b1;
                w_winner    = w_scan;
            end
            w_scan = f_next(w_scan);
        end
    end

    always_comb begin
        case (r_sel)
            3'd0:    w_head_flit = flit_id_i[2:0];
            3'd1:    w_head_flit = flit_id_i[5:3];
            3'd2:    w_head_flit = flit_id_i[8:6];
            3'd3:    w_head_flit = flit_id_i[11:9];
            3'd4:    w_head_flit = flit_id_i[14:12];
            default: w_head_flit = 3'b000;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= c_PTR_RST;
            r_grant <= 5'd0;
            r_sel   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // FSM next-state logic; req_i is deliberately ignored while BUSY
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        case (r_state)
            c_ST_IDLE: begin
                w_grant_nxt = 5'd0;
                if (w_req_found) begin
                    w_state_nxt = c_ST_BUSY;
                    w_grant_nxt = 5'b00001 << w_winner;
                    w_sel_nxt   = w_winner;
                end
            end
            c_ST_BUSY: begin
                if (w_tail_pop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_grant_nxt = 5'd0;
                    w_ptr_nxt   = r_sel;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = 5'd0;
            end
        endcase
    end

    // FSM outputs: pop straight from registered grant, FIFO state and credits
    always_comb begin
        w_cred_ok = (r_credit_cnt != '0);
        w_pop     = 5'd0;
        if ((r_state == c_ST_BUSY) && w_cred_ok) begin
            w_pop = r_grant & ~empty_i;
        end
        read_en_o  = w_pop;
        valid_o    = |w_pop;
        w_tail_pop = (|w_pop) && (w_head_flit == FLIT_TAIL);
    end

    // A send and a returned credit in the same cycle cancel out.
    always_comb begin
        case ({valid_o, credit_in})
            2'b10:   w_credit_nxt = r_credit_cnt - CW'(1);
            2'b01:   w_credit_nxt = (r_credit_cnt >= c_CRED_MAX) ? r_credit_cnt
                                                                 : r_credit_cnt + CW'(1);
            default: w_credit_nxt = r_credit_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit_cnt <= c_CRED_MAX;
        end else begin
            r_credit_cnt <= w_credit_nxt;
        end
    end

    assign grant_o      = r_grant;
    assign sel_o        = r_sel;
    assign credit_cnt_o = r_credit_cnt;

endmodule
`default_nettype wire
